cnt_arb: RTL and testbench
==========================

CNT_ARB -- requirements
Module: cnt_arb

Interface
REQ-001 Parameter W, default 3, is the counter width in bits; legal range 2..16.
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 clr  input  1  reset, asynchronous, active-high.
REQ-004 req_a  input  1  requester A step request, level, held until granted.
REQ-005 dir_a  input  1  requester A direction: 1 = up (+1), 0 = down (-1); sampled with req_a.
REQ-006 req_b  input  1  requester B step request, level, held until granted.
REQ-007 dir_b  input  1  requester B direction, same encoding as dir_a.
REQ-008 gnt_a  output  1  one-cycle grant/acknowledge to A, registered.
REQ-009 gnt_b  output  1  one-cycle grant/acknowledge to B, registered.
REQ-010 Q  output  W  shared counter value, registered.
REQ-011 busy  output  1  high whenever FSM is not IDLE.
REQ-012 edge_flag  output  1  sticky: set when a step hits a boundary (wrap or saturate), cleared only by clr.

Function
REQ-013 FSM states IDLE, STEP, ACK; busy = (state != IDLE).
REQ-014 IDLE: requests sampled only here; on an edge with req_a or req_b high, latch winner and winner's dir, go STEP; otherwise stay IDLE, Q holds.
REQ-015 Arbitration round-robin: single request wins outright; both high -> requester named by priority pointer prio wins.
REQ-016 prio flips to the non-winner at the edge leaving ACK; prio reset value = A.
REQ-017 STEP: at the edge leaving STEP, Q <= Q+1 (dir=1) or Q-1 (dir=0), modulo 2^W; go ACK.
REQ-018 ACK: winner's gnt high for exactly this one cycle, other gnt low; at the edge leaving ACK, go IDLE.
REQ-019 Requester shall deassert req at the edge ending its gnt cycle; a req still high in the following IDLE cycle is a new request.
REQ-020 Latency: req high at IDLE edge k -> Q updated at edge k+1 -> gnt high between edges k+1 and k+2 -> IDLE after edge k+2; throughput one step per 3 cycles.
REQ-021 Losing requester keeps req high; served in the next IDLE cycle (no starvation: max wait one transaction).
REQ-022 Direction changes while busy are ignored; latched dir is used.
REQ-023 Boundary: up from 2^W-1 or down from 0 sets edge_flag at the same edge Q updates.
REQ-024 gnt_a and gnt_b never high together; gnt never high outside ACK.

Reset
REQ-025 clr high asynchronously forces state=IDLE, Q=0, gnt_a=0, gnt_b=0, busy=0, edge_flag=0, prio=A.
REQ-026 clr asserted mid-transaction (STEP or ACK) aborts it: no gnt issued, no Q update; request must be re-presented.
REQ-027 While clr high, requests ignored; first sampling is at the first rising clk edge after clr falls.

Configuration
REQ-028 Macro CNT_ARB_SAT_EN defined: up at 2^W-1 leaves Q at 2^W-1, down at 0 leaves Q at 0; edge_flag still set; gnt still issued.
REQ-029 Macro CNT_ARB_SAT_EN undefined: Q wraps modulo 2^W per REQ-017.

Verification (W=3)
REQ-030 clr pulse, no requests -> Q=0, gnt_a=gnt_b=0, busy=0, edge_flag=0.
REQ-031 req_a=1,dir_a=1 twice (released after each gnt_a) -> Q=3'b010, two single-cycle gnt_a pulses, 3 cycles apart.
REQ-032 req_a and req_b both held, dir_a=1, dir_b=0, from Q=2 -> grants A,B,A,B alternate, Q sequence 3,2,3,2.
REQ-033 From Q=7, up step -> Q=0, edge_flag=1 (without CNT_ARB_SAT_EN); Q=7, edge_flag=1 (with CNT_ARB_SAT_EN).
REQ-034 clr asserted during STEP -> Q=0, no gnt pulse, state IDLE; re-presented request completes normally.
REQ-035 dir_b toggled during STEP/ACK -> step uses latched dir_b; Q changes by exactly 1 in the latched direction.

Source files
------------

// File: rtl/cnt_arb.sv
// cnt_arb: two-requester round-robin arbiter around a shared up/down counter.
// Each granted request steps Q by one in three cycles (IDLE -> STEP -> ACK).
// Optional build macro CNT_ARB_SAT_EN: saturate at the counter limits instead of wrapping.
module cnt_arb #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         req_a,
    input  logic         dir_a,
    input  logic         req_b,
    input  logic         dir_b,
    output logic         gnt_a,
    output logic         gnt_b,
    output logic [W-1:0] Q,
    output logic         busy,
    output logic         edge_flag
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] STEP = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    logic [1:0]   state;
    logic [1:0]   state_nx;
    logic         win_b;      // latched winner: 1 = B, 0 = A
    logic         win_b_nx;
    logic         dir_l;      // latched direction of the winner
    logic         dir_l_nx;
    logic         prio_b;     // round-robin pointer: 1 = B has priority on a tie
    logic         prio_b_nx;
    logic [W-1:0] q_nx;
    logic         gnt_a_nx;
    logic         gnt_b_nx;
    logic         edge_nx;
    logic         at_bound;
    logic [W-1:0] q_step;

    // Boundary detect and stepped counter value for the latched direction
    always_comb begin
        at_bound = dir_l ? (Q == {W{1'b1}}) : (Q == '0);
`ifdef CNT_ARB_SAT_EN
        if (at_bound) begin
            q_step = Q;
        end else begin
            q_step = dir_l ? (Q + W'(1)) : (Q - W'(1));
        end
`else
        q_step = dir_l ? (Q + W'(1)) : (Q - W'(1));
`endif
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx  = state;
        win_b_nx  = win_b;
        dir_l_nx  = dir_l;
        prio_b_nx = prio_b;
        q_nx      = Q;
        gnt_a_nx  = 1'b0;
        gnt_b_nx  = 1'b0;
        edge_nx   = edge_flag;
        case (state)
            IDLE: begin
                if (req_a || req_b) begin
                    win_b_nx = req_b && (!req_a || prio_b);
                    dir_l_nx = win_b_nx ? dir_b : dir_a;
                    state_nx = STEP;
                end
            end
            STEP: begin
                q_nx     = q_step;
                edge_nx  = edge_flag || at_bound;
                gnt_a_nx = !win_b;
                gnt_b_nx = win_b;
                state_nx = ACK;
            end
            ACK: begin
                prio_b_nx = !win_b;
                state_nx  = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and output registers; clr aborts any transaction in flight
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            win_b     <= 1'b0;
            dir_l     <= 1'b0;
            prio_b    <= 1'b0;
            Q         <= '0;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            edge_flag <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            win_b     <= win_b_nx;
            dir_l     <= dir_l_nx;
            prio_b    <= prio_b_nx;
            Q         <= q_nx;
            gnt_a     <= gnt_a_nx;
            gnt_b     <= gnt_b_nx;
            edge_flag <= edge_nx;
            busy      <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_cnt_arb.sv
// Testbench for cnt_arb (W=3): table-driven transactions with a grant scoreboard,
// plus hand sequences for direction changes, boundaries and clr aborts.
module tb_cnt_arb;

    logic       clk = 1'b0;
    logic       clr;
    logic       req_a;
    logic       dir_a;
    logic       req_b;
    logic       dir_b;
    logic       gnt_a;
    logic       gnt_b;
    logic [2:0] Q;
    logic       busy;
    logic       edge_flag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       ra;
        logic       da;
        logic       rb;
        logic       db;
        logic       exp_b;
        logic [2:0] exp_q;
        logic       exp_e;
    } vec_t;

    typedef struct {
        logic       b;
        logic [2:0] q;
        logic       e;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];

`ifdef CNT_ARB_SAT_EN
    localparam logic [2:0] DOWN_FROM_0 = 3'd0;
    localparam logic [2:0] UP_FROM_7   = 3'd7;
`else
    localparam logic [2:0] DOWN_FROM_0 = 3'd7;
    localparam logic [2:0] UP_FROM_7   = 3'd0;
`endif

    cnt_arb #(.W(3)) dut (
        .clk       (clk),
        .clr       (clr),
        .req_a     (req_a),
        .dir_a     (dir_a),
        .req_b     (req_b),
        .dir_b     (dir_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .Q         (Q),
        .busy      (busy),
        .edge_flag (edge_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic ra, input logic da, input logic rb, input logic db,
                                input logic eb, input logic [2:0] q, input logic e);
        vec_t v;
        v.ra = ra; v.da = da; v.rb = rb; v.db = db;
        v.exp_b = eb; v.exp_q = q; v.exp_e = e;
        return v;
    endfunction

    // Scoreboard: every grant pops one expected transaction result
    always @(negedge clk) begin
        if (gnt_a || gnt_b) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_gnt: gnt_a=%0d gnt_b=%0d with nothing pending at %0t",
                         gnt_a, gnt_b, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_gnt_a", int'(gnt_a), int'(!e.b));
                chk("sb_gnt_b", int'(gnt_b), int'(e.b));
                chk("sb_q", int'(Q), int'(e.q));
                chk("sb_edge_flag", int'(edge_flag), int'(e.e));
                chk("sb_busy", int'(busy), 1);
            end
        end
    end

    // Count negedges until a grant is visible (bounded)
    task automatic wait_gnt(output int lat);
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            lat++;
            if (gnt_a || gnt_b) break;
        end
    endtask

    task automatic run_txn(input vec_t v);
        int lat;
        exp_t e;
        @(negedge clk);
        req_a = v.ra; dir_a = v.da; req_b = v.rb; dir_b = v.db;
        e.b = v.exp_b; e.q = v.exp_q; e.e = v.exp_e;
        sb.push_back(e);
        wait_gnt(lat);
        chk("latency", lat, 2);
        if (gnt_a) req_a = 1'b0;
        if (gnt_b) req_b = 1'b0;
    endtask

    // B request whose dir_b flips while the transaction is in flight
    task automatic toggle_txn(input logic d, input logic [2:0] q);
        exp_t e;
        @(negedge clk);
        req_a = 1'b0; req_b = 1'b1; dir_b = d;
        e.b = 1'b1; e.q = q; e.e = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1 dir_b = ~d;
        chk("busy_step", int'(busy), 1);
        @(negedge clk);
        chk("no_early_gnt_b", int'(gnt_b), 0);
        @(posedge clk);
        #1 dir_b = d;
        @(negedge clk);
        chk("gnt_b_ack", int'(gnt_b), 1);
        req_b = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        exp_t e;

        vecs[0] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0);
        vecs[1] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0);
        vecs[2] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0);
        vecs[3] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0);
        vecs[4] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0);
        vecs[5] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0);
        vecs[6] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0);
        vecs[7] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0);
        vecs[8] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0);
        vecs[9] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        clr = 1'b1; req_a = 1'b0; dir_a = 1'b0; req_b = 1'b0; dir_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_q", int'(Q), 0);
        chk("rst_gnt_a", int'(gnt_a), 0);
        chk("rst_gnt_b", int'(gnt_b), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_edge_flag", int'(edge_flag), 0);
        @(negedge clk);
        clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_q_holds", int'(Q), 0);

        for (int i = 0; i < 10; i++) run_txn(vecs[i]);

        toggle_txn(1'b1, 3'd1);
        toggle_txn(1'b0, 3'd0);

        // Boundary: down from 0, then climb to 7 and step up
        run_txn(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, DOWN_FROM_0, 1'b1));
        @(negedge clk);
        chk("edge_sticky", int'(edge_flag), 1);
        clr = 1'b1;
        #1;
        chk("clr_edge_flag", int'(edge_flag), 0);
        chk("clr_q", int'(Q), 0);
        @(negedge clk);
        clr = 1'b0;
        for (int i = 1; i <= 7; i++) run_txn(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'(i), 1'b0));
        run_txn(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, UP_FROM_7, 1'b1));

        // clr during STEP aborts; requests ignored while clr is held
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        req_a = 1'b1; dir_a = 1'b1;
        @(posedge clk);
        #2;
        chk("busy_before_abort", int'(busy), 1);
        clr = 1'b1;
        #1;
        chk("abort_q", int'(Q), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_gnt_a", int'(gnt_a), 0);
        repeat (3) @(negedge clk);
        chk("clr_held_busy", int'(busy), 0);
        chk("clr_held_q", int'(Q), 0);
        clr = 1'b0;
        e.b = 1'b0; e.q = 3'd1; e.e = 1'b0;
        sb.push_back(e);
        wait_gnt(lat);
        chk("represent_latency", lat, 2);
        req_a = 1'b0;
        @(negedge clk);
        chk("final_busy", int'(busy), 0);
        chk("final_gnt_a", int'(gnt_a), 0);
        chk("final_q", int'(Q), 1);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
